matmul_mac_sequencer: RTL and testbench



---
 rtl/matmul_mac_sequencer.sv | 94 +++++++++
 tb/tb_matmul_mac_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/matmul_mac_sequencer.sv
// matmul_mac_sequencer: sequential C = A x B using one shared multiply-accumulate step per cycle
module matmul_mac_sequencer #(
  parameter int DW    = 32,
  parameter int ROWS  = 4,
  parameter int INNER = 2,
  parameter int COLS  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ROWS*INNER*DW-1:0]  a,
  input  logic [INNER*COLS*DW-1:0]  b,
  output logic                      busy,
  output logic                      done,
  output logic [ROWS*COLS*DW-1:0]   result,
  output logic                      elem_valid,
  output logic [7:0]                elem_index,
  output logic [DW-1:0]             elem_data
);
  localparam int NA = ROWS * INNER;
  localparam int NB = INNER * COLS;
  localparam int NC = ROWS * COLS;
  typedef enum logic [1:0] {IDLE, MAC, FIN} state_t;
  state_t state;
  logic [NA*DW-1:0] a_r;
  logic [NB*DW-1:0] b_r;
  logic [NC*DW-1:0] cbuf;
  logic [DW-1:0] acc, acc_next, ae, be;
  logic [7:0] i, j, k;
  int ai, bi, ci;
  always_comb begin
    ai = int'(i) * INNER + int'(k);
    bi = int'(k) * COLS + int'(j);
    ci = int'(i) * COLS + int'(j);
    ae = a_r[DW*(NA-1-ai) +: DW];
    be = b_r[DW*(NB-1-bi) +: DW];
    acc_next = (k == 8'd0 ? '0 : acc) + ae * be;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      elem_valid <= 1'b0;
      elem_index <= '0;
      elem_data  <= '0;
      result     <= '0;
      cbuf       <= '0;
      acc        <= '0;
      a_r        <= '0;
      b_r        <= '0;
      i          <= '0;
      j          <= '0;
      k          <= '0;
    end else begin
      done       <= 1'b0;
      elem_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_r   <= a;
          b_r   <= b;
          i     <= '0;
          j     <= '0;
          k     <= '0;
          acc   <= '0;
          busy  <= 1'b1;
          state <= MAC;
        end
        MAC: if (k == 8'(INNER-1)) begin
          cbuf[DW*(NC-1-ci) +: DW] <= acc_next;
          elem_valid <= 1'b1;
          elem_index <= 8'(ci);
          elem_data  <= acc_next;
          k          <= '0;
          j          <= (j == 8'(COLS-1)) ? 8'd0 : j + 8'd1;
          if (j == 8'(COLS-1)) begin
            i     <= (i == 8'(ROWS-1)) ? 8'd0 : i + 8'd1;
            state <= (i == 8'(ROWS-1)) ? FIN : MAC;
          end
        end else begin
          acc <= acc_next;
          k   <= k + 8'd1;
        end
        FIN: begin
          result <= cbuf;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_mac_sequencer.sv
// tb_matmul_mac_sequencer: directed scenario tests for the sequential matrix multiplier
module tb_matmul_mac_sequencer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [255:0] a_in = '0, b_in = '0;
  logic busy, done, elem_valid;
  logic [511:0] result;
  logic [7:0] elem_index;
  logic [31:0] elem_data;
  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0, t0 = 0;
  int done_cnt = 0, last_done = 0, prev_done = 0;
  int ev_cnt = 0, ev_seq = 0, ev_order_err = 0;
  localparam logic [255:0] A_MAIN = {32'd2, 32'd3, 32'd4, 32'd2, 32'd4, 32'd2, 32'd3, 32'd2};
  localparam logic [255:0] B_MAIN = {32'd1, 32'd2, 32'd3, 32'd2, 32'd3, 32'd1, 32'd3, 32'd2};
  localparam logic [511:0] C_MAIN = {32'd11, 32'd7, 32'd15, 32'd10, 32'd10, 32'd10, 32'd18, 32'd12,
                                     32'd10, 32'd10, 32'd18, 32'd12, 32'd9, 32'd8, 32'd15, 32'd10};
  localparam logic [255:0] A_WRAP = {32'hFFFFFFFF, 32'd1, 192'd0};
  localparam logic [255:0] B_WRAP = {32'd2, 96'd0, 32'd3, 96'd0};
  localparam logic [511:0] C_WRAP = {32'd1, 480'd0};

  matmul_mac_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .a(a_in), .b(b_in),
    .busy(busy), .done(done), .result(result),
    .elem_valid(elem_valid), .elem_index(elem_index), .elem_data(elem_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      prev_done = last_done;
      last_done = cyc;
    end
    if (reset) ev_seq = 0;
    else if (elem_valid) begin
      if (elem_index != 8'(ev_seq)) ev_order_err++;
      ev_seq = (ev_seq + 1) % 16;
      ev_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step_to(input int n);
    while (cyc < t0 + n) @(negedge clk);
  endtask

  task automatic start_job(input logic [255:0] av, input logic [255:0] bv);
    @(negedge clk);
    a_in = av;
    b_in = bv;
    start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (elem_valid !== 1'b0) $display("FAIL reset_ev: got %b want 0", elem_valid); else pass_cnt++;
    total_cnt++; if (result !== '0) $display("FAIL reset_result: got %h want 0", result); else pass_cnt++;
    total_cnt++; if (elem_index !== 8'd0 || elem_data !== 32'd0)
      $display("FAIL reset_elem: got %0d/%0h want 0/0", elem_index, elem_data); else pass_cnt++;
  endtask

  task automatic test_basic;
    int d0, e0, o0;
    d0 = done_cnt; e0 = ev_cnt; o0 = ev_order_err;
    start_job(A_MAIN, B_MAIN);
    step_to(1);
    total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy_t1: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (elem_valid !== 1'b0) $display("FAIL basic_ev_t1: got %b want 0", elem_valid); else pass_cnt++;
    step_to(2);
    total_cnt++; if (elem_valid !== 1'b1 || elem_index !== 8'd0 || elem_data !== 32'd11)
      $display("FAIL basic_first_elem: got %b/%0d/%0d want 1/0/11", elem_valid, elem_index, elem_data); else pass_cnt++;
    step_to(32);
    total_cnt++; if (elem_valid !== 1'b1 || elem_index !== 8'd15 || elem_data !== 32'd10)
      $display("FAIL basic_last_elem: got %b/%0d/%0d want 1/15/10", elem_valid, elem_index, elem_data); else pass_cnt++;
    total_cnt++; if (result !== '0 || busy !== 1'b1)
      $display("FAIL basic_hold_t32: got result %h busy %b want 0/1", result, busy); else pass_cnt++;
    step_to(33);
    total_cnt++; if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL basic_done_t33: got done %b busy %b want 1/0", done, busy); else pass_cnt++;
    step_to(34);
    total_cnt++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (result !== C_MAIN) $display("FAIL basic_result: got %h want %h", result, C_MAIN); else pass_cnt++;
    total_cnt++; if (done_cnt - d0 != 1 || last_done != t0 + 33)
      $display("FAIL basic_done_count: got %0d at %0d want 1 at %0d", done_cnt - d0, last_done, t0 + 33); else pass_cnt++;
    total_cnt++; if (ev_cnt - e0 != 16 || ev_order_err != o0)
      $display("FAIL basic_elem_stream: got %0d pulses %0d order errors want 16/0", ev_cnt - e0, ev_order_err - o0); else pass_cnt++;
  endtask

  task automatic test_wrap;
    int d0;
    d0 = done_cnt;
    start_job(A_WRAP, B_WRAP);
    step_to(2);
    total_cnt++; if (elem_data !== 32'h00000001) $display("FAIL wrap_elem0: got %h want 00000001", elem_data); else pass_cnt++;
    step_to(34);
    total_cnt++; if (result !== C_WRAP) $display("FAIL wrap_result: got %h want %h", result, C_WRAP); else pass_cnt++;
    total_cnt++; if (done_cnt - d0 != 1) $display("FAIL wrap_done_count: got %0d want 1", done_cnt - d0); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    a_in = A_MAIN;
    b_in = B_MAIN;
    start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    step_to(5);
    a_in = A_WRAP;
    b_in = B_WRAP;
    step_to(33);
    total_cnt++; if (done !== 1'b1 || result !== C_MAIN)
      $display("FAIL held_first_result: got done %b result %h want 1/%h", done, result, C_MAIN); else pass_cnt++;
    step_to(34);
    total_cnt++; if (busy !== 1'b1) $display("FAIL held_second_accept: got busy %b want 1", busy); else pass_cnt++;
    step_to(40);
    start = 1'b0;
    step_to(75);
    total_cnt++; if (done_cnt - d0 != 2 || last_done - prev_done != 34)
      $display("FAIL held_done_spacing: got %0d pulses spacing %0d want 2/34", done_cnt - d0, last_done - prev_done); else pass_cnt++;
    total_cnt++; if (result !== C_WRAP) $display("FAIL held_second_result: got %h want %h", result, C_WRAP); else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    int d0;
    d0 = done_cnt;
    start_job(A_MAIN, B_MAIN);
    step_to(11);
    reset = 1'b1;
    step_to(12);
    total_cnt++; if (busy !== 1'b0 || result !== '0)
      $display("FAIL midreset_state: got busy %b result %h want 0/0", busy, result); else pass_cnt++;
    reset = 1'b0;
    step_to(50);
    total_cnt++; if (done_cnt != d0) $display("FAIL midreset_no_done: got %0d pulses want 0", done_cnt - d0); else pass_cnt++;
    start_job(A_WRAP, B_WRAP);
    step_to(34);
    total_cnt++; if (result !== C_WRAP || done_cnt - d0 != 1)
      $display("FAIL midreset_restart: got %h (%0d done) want %h (1 done)", result, done_cnt - d0, C_WRAP); else pass_cnt++;
  endtask

  task automatic test_start_while_busy;
    int d0;
    d0 = done_cnt;
    start_job(A_MAIN, B_MAIN);
    step_to(9);
    a_in = A_WRAP;
    b_in = B_WRAP;
    start = 1'b1;
    step_to(10);
    start = 1'b0;
    step_to(45);
    total_cnt++; if (done_cnt - d0 != 1) $display("FAIL busy_start_done_count: got %0d want 1", done_cnt - d0); else pass_cnt++;
    total_cnt++; if (result !== C_MAIN) $display("FAIL busy_start_result: got %h want %h", result, C_MAIN); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL busy_start_idle: got busy %b want 0", busy); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_back_to_back;
    test_mid_reset;
    test_start_while_busy;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
